// File: rtl/k2red_stream.sv
// Streaming multiplier front-end and result collector for an external K2RED reducer.
// Operands are multiplied in two stages, tracked through the reducer latency, and the results are queued in a FWFT FIFO.
module k2red_stream #(
    parameter int WID    = 12,
    parameter int KLAT   = 5,
    parameter int FDEPTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WID-1:0]     a_in,
    input  logic [WID-1:0]     b_in,
    output logic [2*WID-1:0]   c_out,
    input  logic [WID-1:0]     cred_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WID-1:0]     out_data,
    output logic               busy
);

    localparam int AW = (FDEPTH > 1) ? $clog2(FDEPTH) : 1;
    localparam int CW = $clog2(FDEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(FDEPTH);

    logic               accept;
    logic               pop;
    logic               vk;

    logic [WID-1:0]     a1_reg;
    logic [WID-1:0]     b1_reg;
    logic               v1_reg;
    logic [2*WID-1:0]   c_out_reg;
    logic               v2_reg;
    logic [2*WID-1:0]   prod_next;
    logic [KLAT-1:0]    vdl_reg;

    logic [WID-1:0]     mem [FDEPTH];
    logic [AW-1:0]      wr_ptr_reg;
    logic [AW-1:0]      rd_ptr_reg;
    logic [CW-1:0]      fcount_reg;
    logic [CW-1:0]      fcount_next;
    logic [CW-1:0]      used_reg;
    logic [CW-1:0]      used_next;

    // Credit state alone decides in_ready, so out_ready never reaches it combinationally.
    assign in_ready  = (used_reg != FULL_CNT);
    assign busy      = (used_reg != '0);
    assign out_valid = (fcount_reg != '0);
    assign out_data  = mem[rd_ptr_reg];
    assign c_out     = c_out_reg;

    assign accept = in_valid & in_ready;
    assign pop    = out_valid & out_ready;

    // Stage 1: operand capture.
    always_ff @(posedge clk) begin
        if (accept) begin
            a1_reg <= a_in;
            b1_reg <= b_in;
        end
    end

    assign prod_next = {{WID{1'b0}}, a1_reg} * {{WID{1'b0}}, b1_reg};

    // Stage 2 loads every cycle; the reducer output is only kept when tracked valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_reg    <= 1'b0;
            v2_reg    <= 1'b0;
            c_out_reg <= '0;
        end else begin
            v1_reg    <= accept;
            v2_reg    <= v1_reg;
            c_out_reg <= prod_next;
        end
    end

    generate
        for (genvar gi = 0; gi < KLAT; gi++) begin : g_vdl
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vdl_reg[gi] <= 1'b0;
                end else if (gi == 0) begin
                    vdl_reg[gi] <= v2_reg;
                end else begin
                    vdl_reg[gi] <= vdl_reg[(gi > 0) ? gi - 1 : 0];
                end
            end
        end
    endgenerate

    assign vk = vdl_reg[KLAT-1];

    always_ff @(posedge clk) begin
        if (vk) begin
            mem[wr_ptr_reg] <= cred_in;
        end
    end

    always_comb begin
        fcount_next = fcount_reg;
        case ({vk, pop})
            2'b10:   fcount_next = fcount_reg + CW'(1);
            2'b01:   fcount_next = fcount_reg - CW'(1);
            default: fcount_next = fcount_reg;
        endcase
    end

    always_comb begin
        used_next = used_reg;
        case ({accept, pop})
            2'b10:   used_next = used_reg + CW'(1);
            2'b01:   used_next = used_reg - CW'(1);
            default: used_next = used_reg;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            fcount_reg <= '0;
            used_reg   <= '0;
        end else begin
            if (vk) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            fcount_reg <= fcount_next;
            used_reg   <= used_next;
        end
    end

endmodule

// File: tb/tb_k2red_stream.sv
// Randomized and directed bench for k2red_stream with a behavioural reducer and scoreboard model.
module tb_k2red_stream;

    localparam int WID    = 12;
    localparam int KLAT   = 5;
    localparam int FDEPTH = 16;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [WID-1:0]     a_in = '0;
    logic [WID-1:0]     b_in = '0;
    logic [2*WID-1:0]   c_out;
    logic [WID-1:0]     cred_in;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [WID-1:0]     out_data;
    logic               busy;

    k2red_stream #(.WID(WID), .KLAT(KLAT), .FDEPTH(FDEPTH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a_in(a_in), .b_in(b_in), .c_out(c_out), .cred_in(cred_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int acc_total = 0;
    int used_m   = 0;

    typedef struct { int cyc; logic [WID-1:0] val; } res_t;
    typedef struct { int cyc; logic [2*WID-1:0] prod; } prod_t;
    res_t  res_q[$];
    prod_t prod_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
        end
    endtask

    // Two K-RED steps for q = 13*2^8+1, truncated to the result width.
    function automatic logic [WID-1:0] k2red(input int c);
        int c1, c2;
        logic [31:0] t;
        c1 = 13 * (c & 255) - (c >>> 8);
        c2 = 13 * (c1 & 255) - (c1 >>> 8);
        t = c2;
        return t[WID-1:0];
    endfunction

    // Behavioural reducer: fixed KLAT-cycle latency, cannot stall.
    logic [WID-1:0] rpipe [KLAT];
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < KLAT; i++) rpipe[i] <= '0;
        end else begin
            rpipe[0] <= k2red(int'(c_out));
            for (int i = 1; i < KLAT; i++) rpipe[i] <= rpipe[i-1];
        end
    end
    assign cred_in = rpipe[KLAT-1];

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: everything sampled at the falling edge, mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            res_q.delete();
            prod_q.delete();
            used_m = 0;
        end else begin
            logic acc, popm, exp_ov;
            acc    = in_valid & in_ready;
            exp_ov = (res_q.size() > 0) && (res_q[0].cyc + 3 + KLAT <= cyc);
            popm   = exp_ov & out_ready;
            chk("in_ready", {31'd0, in_ready}, {31'd0, used_m != FDEPTH});
            chk("busy", {31'd0, busy}, {31'd0, used_m != 0});
            chk("out_valid", {31'd0, out_valid}, {31'd0, exp_ov});
            chk("ovf", {31'd0, dut.vk & (dut.fcount_reg == FDEPTH) & ~(out_valid & out_ready)}, 32'd0);
            if (prod_q.size() > 0 && prod_q[0].cyc == cyc) begin
                chk("c_out", {8'd0, c_out}, {8'd0, prod_q[0].prod});
                void'(prod_q.pop_front());
            end
            if (popm) begin
                chk("out_data", {20'd0, out_data}, {20'd0, res_q[0].val});
                void'(res_q.pop_front());
            end
            if (acc) begin
                res_t r;
                prod_t p;
                r.cyc = cyc;
                r.val = k2red(int'(a_in) * int'(b_in));
                p.cyc = cyc + 2;
                p.prod = (2*WID)'(int'(a_in) * int'(b_in));
                res_q.push_back(r);
                prod_q.push_back(p);
                acc_total++;
            end
            used_m = used_m + (acc ? 1 : 0) - (popm ? 1 : 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [WID-1:0] a, input logic [WID-1:0] b);
        in_valid = 1'b1;
        a_in = a;
        b_in = b;
        tick();
    endtask

    int acc_base;
    logic [WID-1:0] edge_a [3];
    logic [WID-1:0] edge_b [3];

    initial begin
        edge_a[0] = 12'd0;    edge_b[0] = 12'd3328;
        edge_a[1] = 12'd1;    edge_b[1] = 12'd1;
        edge_a[2] = 12'd4095; edge_b[2] = 12'd4095;

        rst = 1'b1;
        tick(); tick();
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_c_out", {8'd0, c_out}, 32'd0);
        rst = 1'b0;
        out_ready = 1'b1;
        tick();

        // Single maximal beat.
        beat(12'd3328, 12'd3328);
        in_valid = 1'b0;
        tick();
        chk("c_out_max", {8'd0, c_out}, 32'd11075584);
        repeat (12) tick();

        // Back-to-back stream.
        for (int i = 0; i < 20; i++) beat(WID'(i), 12'd17);
        in_valid = 1'b0;
        repeat (15) tick();

        // Backpressure: fill credits, then pop and accept together.
        out_ready = 1'b0;
        acc_base = acc_total;
        for (int i = 0; i < 25; i++) beat(WID'($urandom_range(0, 3328)), WID'($urandom_range(0, 3328)));
        chk("fill_accepts", acc_total - acc_base, FDEPTH);
        chk("fill_in_ready", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) beat(WID'($urandom_range(0, 3328)), WID'($urandom_range(0, 3328)));
        in_valid = 1'b0;
        repeat (40) tick();
        chk("drain_in_ready", {31'd0, in_ready}, 32'd1);

        // Edge operands.
        for (int i = 0; i < 3; i++) beat(edge_a[i], edge_b[i]);
        in_valid = 1'b0;
        tick();
        chk("c_out_4095sq", {8'd0, c_out}, 32'd16769025);
        repeat (12) tick();

        // Random handshakes.
        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 1) != 0);
            a_in = WID'($urandom);
            b_in = WID'($urandom);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (60) tick();
        chk("rand_drained", res_q.size(), 32'd0);

        // Reset with beats in flight.
        for (int i = 0; i < 6; i++) beat(WID'($urandom_range(0, 3328)), WID'($urandom_range(0, 3328)));
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        rst = 1'b0;
        repeat (12) tick();
        chk("no_stale", {31'd0, out_valid}, 32'd0);
        beat(12'd1234, 12'd2345);
        in_valid = 1'b0;
        repeat (15) tick();
        chk("final_empty", res_q.size(), 32'd0);
        chk("final_busy", {31'd0, busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
